// File: rtl/elink_trig_scrubber_mc.sv
// Multi-channel trigger e-link scrubber.
// Keeps one golden word per channel and periodically sweeps every channel.
// Each live word is compared with its golden copy. A mismatch bumps a
// saturating per-channel error counter and raises a ready/valid correction
// request that carries the golden value. A pipelined Wishbone slave gives
// access to the golden words, the counters and the enable bit. The slave
// stalls for the whole sweep, so bus writes never race the counter updates.
module elink_trig_scrubber_mc #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 10,
   parameter int ADDR_W = 4,
   parameter int CNT_W  = 8,
   parameter int PERIOD = 16
) (
   input  logic                                           clk,
   input  logic                                           rst_n,
   input  logic [ADDR_W-1:0]                              i_wb_addr,
   input  logic                                           i_wb_stb,
   input  logic                                           i_wb_we,
   input  logic [DATA_W-1:0]                              i_wb_data,
   output logic [DATA_W-1:0]                              o_wb_data,
   output logic                                           o_wb_ack,
   output logic                                           o_wb_stall,
   input  logic [NUM_CH*DATA_W-1:0]                       i_live_data,
   output logic                                           o_fix_valid,
   input  logic                                           i_fix_ready,
   output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] o_fix_ch,
   output logic [DATA_W-1:0]                              o_fix_data
);

   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int TMR_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(PERIOD - 1);
   localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);
   localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(2 * NUM_CH);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CMP,
      ST_FIX
   } state_t;

   state_t              state_reg, state_next;
   logic [CH_W-1:0]     ch_reg, ch_next;
   logic [TMR_W-1:0]    timer_reg, timer_next;
   logic                fix_valid_reg, fix_valid_next;
   logic [CH_W-1:0]     fix_ch_reg, fix_ch_next;
   logic [DATA_W-1:0]   fix_data_reg, fix_data_next;
   logic                enable_reg;
   logic                ack_reg;
   logic [DATA_W-1:0]   rdata_reg;

   logic [DATA_W-1:0]   live_arr   [NUM_CH];
   logic [DATA_W-1:0]   golden_arr [NUM_CH];
   logic [CNT_W-1:0]    errcnt_arr [NUM_CH];
   logic [NUM_CH-1:0]   gold_sel;
   logic [NUM_CH-1:0]   cnt_sel;

   logic                wb_accept;
   logic                wb_wr;
   logic [DATA_W-1:0]   rd_data;
   logic [DATA_W-1:0]   live_cur;
   logic [DATA_W-1:0]   golden_cur;
   logic                cnt_inc;

   assign o_wb_stall  = (state_reg != ST_IDLE);
   assign wb_accept   = i_wb_stb & ~o_wb_stall;
   assign wb_wr       = wb_accept & i_wb_we;
   assign o_wb_ack    = ack_reg;
   assign o_wb_data   = rdata_reg;
   assign o_fix_valid = fix_valid_reg;
   assign o_fix_ch    = fix_ch_reg;
   assign o_fix_data  = fix_data_reg;

   // Per-channel storage: golden word, saturating error counter, address decode.
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DATA_W-1:0] golden_reg;
      logic [CNT_W-1:0]  errcnt_reg;

      assign live_arr[gi]   = i_live_data[gi*DATA_W +: DATA_W];
      assign gold_sel[gi]   = (i_wb_addr == ADDR_W'(gi));
      assign cnt_sel[gi]    = (i_wb_addr == ADDR_W'(NUM_CH + gi));
      assign golden_arr[gi] = golden_reg;
      assign errcnt_arr[gi] = errcnt_reg;

      // Golden word is only ever written from the bus.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            golden_reg <= '0;
         end else if (wb_wr && gold_sel[gi]) begin
            golden_reg <= i_wb_data;
         end
      end

      // Counter bumps on a sweep mismatch and is cleared by any bus write.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            errcnt_reg <= '0;
         end else if (cnt_inc && (ch_reg == CH_W'(gi))) begin
            if (errcnt_reg != CNT_MAX) begin
               errcnt_reg <= errcnt_reg + CNT_W'(1);
            end
         end else if (wb_wr && cnt_sel[gi]) begin
            errcnt_reg <= '0;
         end
      end
   end

   // Select the live and golden words of the channel under comparison.
   always_comb begin
      live_cur   = '0;
      golden_cur = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_reg == CH_W'(i)) begin
            live_cur   = live_arr[i];
            golden_cur = golden_arr[i];
         end
      end
   end

   // Bus read mux; unmapped addresses return zero.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (gold_sel[i]) rd_data = golden_arr[i];
         if (cnt_sel[i])  rd_data = DATA_W'(errcnt_arr[i]);
      end
      if (i_wb_addr == CTRL_ADDR) rd_data = DATA_W'(enable_reg);
   end

   // Bus response: ack one cycle after acceptance, data zero for writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_reg    <= 1'b0;
         rdata_reg  <= '0;
         enable_reg <= 1'b1;
      end else begin
         ack_reg   <= wb_accept;
         rdata_reg <= (wb_accept && !i_wb_we) ? rd_data : '0;
         if (wb_wr && (i_wb_addr == CTRL_ADDR)) begin
            enable_reg <= i_wb_data[0];
         end
      end
   end

   // Sweep FSM state and correction request registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         ch_reg        <= '0;
         timer_reg     <= TMR_LOAD;
         fix_valid_reg <= 1'b0;
         fix_ch_reg    <= '0;
         fix_data_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         ch_reg        <= ch_next;
         timer_reg     <= timer_next;
         fix_valid_reg <= fix_valid_next;
         fix_ch_reg    <= fix_ch_next;
         fix_data_reg  <= fix_data_next;
      end
   end

   // Sweep FSM next state: idle countdown, per-channel compare, fix handshake.
   always_comb begin
      state_next     = state_reg;
      ch_next        = ch_reg;
      timer_next     = timer_reg;
      fix_valid_next = fix_valid_reg;
      fix_ch_next    = fix_ch_reg;
      fix_data_next  = fix_data_reg;
      cnt_inc        = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (enable_reg) begin
               if (timer_reg != '0) begin
                  timer_next = timer_reg - TMR_W'(1);
               end else if (!wb_accept) begin
                  // A request accepted in this cycle pushes the sweep back one cycle.
                  state_next = ST_CMP;
                  ch_next    = '0;
               end
            end
         end
         ST_CMP: begin
            if (live_cur != golden_cur) begin
               cnt_inc        = 1'b1;
               fix_valid_next = 1'b1;
               fix_ch_next    = ch_reg;
               fix_data_next  = golden_cur;
               state_next     = ST_FIX;
            end else if (ch_reg == CH_LAST) begin
               state_next = ST_IDLE;
               timer_next = TMR_LOAD;
            end else begin
               ch_next = ch_reg + CH_W'(1);
            end
         end
         ST_FIX: begin
            if (i_fix_ready) begin
               fix_valid_next = 1'b0;
               if (ch_reg == CH_LAST) begin
                  state_next = ST_IDLE;
                  timer_next = TMR_LOAD;
               end else begin
                  ch_next    = ch_reg + CH_W'(1);
                  state_next = ST_CMP;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: doc/elink_trig_scrubber_mc.md
Name: elink_trig_scrubber_mc

Overview:
Parametrised, multi-channel successor to the single-channel trigger e-link scrubber. It holds one golden word per trigger e-link channel and periodically sweeps all channels. Each sweep compares the live channel word against its golden copy, counts mismatches per channel, and issues a ready/valid correction request carrying the golden value. A Wishbone-style pipelined slave port gives read/write access to the golden words, the error counters and a control register; the port stalls while a sweep is in progress.

Parameters:
NUM_CH, 4, number of trigger e-link channels (1..16)
DATA_W, 10, channel word width and Wishbone data width
ADDR_W, 4, Wishbone address width; must satisfy 2*NUM_CH+1 <= 2**ADDR_W
CNT_W, 8, per-channel error counter width (saturating)
PERIOD, 16, idle cycles between sweeps (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_wb_addr  in  ADDR_W  register address
i_wb_stb  in  1  request strobe
i_wb_we  in  1  1=write, 0=read
i_wb_data  in  DATA_W  write data
o_wb_data  out  DATA_W  read data, valid with o_wb_ack
o_wb_ack  out  1  one-cycle acknowledge
o_wb_stall  out  1  request not accepted this cycle
i_live_data  in  NUM_CH*DATA_W  live channel words; channel k at bits [k*DATA_W +: DATA_W]
o_fix_valid  out  1  correction request valid
i_fix_ready  in  1  correction accepted
o_fix_ch  out  clog2(NUM_CH) (min 1)  channel to correct
o_fix_data  out  DATA_W  golden value to restore

Behaviour:
- Reset (async, rst_n=0): state IDLE, timer=PERIOD-1, golden[*]=0, errcnt[*]=0, enable=1, o_wb_ack=0, o_wb_data=0, o_wb_stall=0, o_fix_valid=0, o_fix_ch=0, o_fix_data=0. Reset during FIX drops o_fix_valid immediately; the pending correction is lost.
- Address map:
  - 0..NUM_CH-1: golden[a], R/W.
  - NUM_CH..2*NUM_CH-1: errcnt[a-NUM_CH], zero-extended on read; any write clears it.
  - 2*NUM_CH: control. Bit0 = enable, R/W; other bits read 0.
  - Other addresses: read 0; writes are ignored but still acked.
- Wishbone:
  - A request is accepted when i_wb_stb=1 and o_wb_stall=0.
  - o_wb_ack=1 exactly one cycle after acceptance. o_wb_data is valid in the ack cycle and is 0 for writes.
  - Back-to-back accepted requests produce back-to-back acks.
  - o_wb_stall is combinational and equals (state != IDLE).
- FSM states: IDLE, CMP, FIX.
  - IDLE: while enable=1 and timer>0, timer decrements each cycle. When timer=0, enable=1 and no request is accepted this cycle, go to CMP with ch=0. An accepted request in that cycle defers the sweep by one cycle. With enable=0, the timer holds.
  - CMP (one cycle per channel): compare live[ch] with golden[ch].
    - On mismatch: errcnt[ch] increments, saturating at 2**CNT_W-1. Load o_fix_ch=ch and o_fix_data=golden[ch], set o_fix_valid=1, go to FIX.
    - On match: if ch=NUM_CH-1, go to IDLE with timer=PERIOD-1; else ch++ and stay in CMP.
  - FIX: hold o_fix_valid, o_fix_ch and o_fix_data stable until i_fix_ready=1. In that handshake cycle, o_fix_valid deasserts the next cycle; then either ch++ and go to CMP, or, if ch was last, go to IDLE with timer reload.
- A sweep with no mismatches lasts exactly NUM_CH cycles of stall.
- Clearing enable mid-sweep does not abort; the current sweep completes.
- Wishbone writes and the counter increment never collide, because the port is stalled during CMP/FIX.
- i_live_data is sampled only in CMP and is treated as synchronous to clk.

Test Plan:
- Reset then idle, PERIOD=16, live=golden=0 → stall high for exactly 4 cycles starting 16 cycles after reset release, o_fix_valid never asserts, all errcnt read 0.
- Write golden[2]=0x155, live ch2=0x0AA, i_fix_ready=1 → o_fix_valid one cycle with o_fix_ch=2, o_fix_data=0x155; errcnt[2] (addr 6) reads 1; the next sweep reads 2.
- Mismatch on ch1 with i_fix_ready held low for 5 cycles → o_fix_valid/ch/data stable for 5 cycles, stall high throughout, sweep resumes at ch2 after the handshake.
- Persistent mismatch, CNT_W=8, 300 sweeps → errcnt saturates at 255; write to addr 5 → reads 0.
- Write control=0 → no sweeps, stall stays 0 for 100 cycles; write control=1 → sweep resumes once the timer expires; read addr 8 returns 1.
- Strobe held high across a sweep boundary → stall blocks acceptance during CMP; every accepted request gets exactly one ack one cycle later; reading unmapped addr 15 returns 0 with ack.
